// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming (7,4) codec arbiter.
package hamming_pkg;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef logic [7:1] code7_t;
    typedef logic [4:1] data4_t;
    typedef logic [3:1] synd_t;

    // Codeword bit positions: parity at powers of two, data elsewhere.
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 2;
    localparam int unsigned D1_POS = 3;
    localparam int unsigned P3_POS = 4;
    localparam int unsigned D2_POS = 5;
    localparam int unsigned D3_POS = 6;
    localparam int unsigned D4_POS = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/hamming74_core.sv
// Combinational Hamming (7,4) encoder and single-error syndrome/corrector.
module hamming74_core
    import hamming_pkg::*;
(
    input  logic   ptype,
    input  data4_t enc_data,
    input  code7_t dec_code,
    output code7_t enc_code_c,
    output synd_t  synd_c,
    output code7_t corr_code_c,
    output data4_t corr_data_c
);

    // Place data bits and compute the three parity bits.
    always_comb begin
        enc_code_c         = '0;
        enc_code_c[D1_POS] = enc_data[1];
        enc_code_c[D2_POS] = enc_data[2];
        enc_code_c[D3_POS] = enc_data[3];
        enc_code_c[D4_POS] = enc_data[4];
        enc_code_c[P1_POS] = enc_data[1] ^ enc_data[2] ^ enc_data[4] ^ ptype;
        enc_code_c[P2_POS] = enc_data[1] ^ enc_data[3] ^ enc_data[4] ^ ptype;
        enc_code_c[P3_POS] = enc_data[2] ^ enc_data[3] ^ enc_data[4] ^ ptype;
    end

    // Syndrome equals the position of a single flipped bit (0 = clean).
    always_comb begin
        synd_c    = '0;
        synd_c[3] = dec_code[4] ^ dec_code[5] ^ dec_code[6] ^ dec_code[7] ^ ptype;
        synd_c[2] = dec_code[2] ^ dec_code[3] ^ dec_code[6] ^ dec_code[7] ^ ptype;
        synd_c[1] = dec_code[1] ^ dec_code[3] ^ dec_code[5] ^ dec_code[7] ^ ptype;
    end

    // Flip the bit the syndrome points at and extract the data bits.
    always_comb begin
        corr_code_c = dec_code;
        for (int unsigned i = 1; i <= 7; i++) begin
            if (32'(synd_c) == i) begin
                corr_code_c[i] = ~dec_code[i];
            end
        end
        corr_data_c = {corr_code_c[D4_POS], corr_code_c[D3_POS],
                       corr_code_c[D2_POS], corr_code_c[D1_POS]};
    end

endmodule

// File: rtl/hamming_codec_arbiter.sv
// Round-robin arbiter sharing one Hamming (7,4) engine among NREQ requesters.
// Optional corrected-error counter enabled by defining HAMMING_ERR_CNT_EN.
module hamming_codec_arbiter
    import hamming_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ-1:0]          req_ptype,
    input  logic [7*NREQ-1:0]        req_word,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_op,
    output logic [6:0]               rsp_code,
    output logic [3:0]               rsp_data,
    output logic [2:0]               rsp_syndrome,
    output logic                     rsp_err,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            op_q, op_d;
    code7_t          code_q, code_d;
    data4_t          data_q, data_d;
    synd_t           syn_q, syn_d;
    logic            err_q, err_d;

    logic            gnt_found_c;
    logic [IDW-1:0]  gnt_idx_c;
    logic            sel_op_c;
    logic            sel_ptype_c;
    logic [6:0]      sel_word_c;
    logic            acc_c;

    code7_t          enc_code_c;
    synd_t           synd_c;
    code7_t          corr_code_c;
    data4_t          corr_data_c;

    // Circular priority search starting just after the last granted index.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        sel_op_c    = 1'b0;
        sel_ptype_c = 1'b0;
        sel_word_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_found_c && req_valid[i] && (i > 32'(last_q))) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = IDW'(i);
                sel_op_c    = req_op[i];
                sel_ptype_c = req_ptype[i];
                sel_word_c  = req_word[7*i +: 7];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_found_c && req_valid[i] && (i <= 32'(last_q))) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = IDW'(i);
                sel_op_c    = req_op[i];
                sel_ptype_c = req_ptype[i];
                sel_word_c  = req_word[7*i +: 7];
            end
        end
    end

    // Accept when the output register is free or being drained this cycle.
    assign acc_c = gnt_found_c && ((state_q == ST_IDLE) || rsp_ready) && !rst;

    // One-hot ready to the granted requester only.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (acc_c && (32'(gnt_idx_c) == i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    hamming74_core u_core (
        .ptype       (sel_ptype_c),
        .enc_data    (sel_word_c[3:0]),
        .dec_code    (sel_word_c),
        .enc_code_c  (enc_code_c),
        .synd_c      (synd_c),
        .corr_code_c (corr_code_c),
        .corr_data_c (corr_data_c)
    );

    // Next state and response register load.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        code_d  = code_q;
        data_d  = data_q;
        syn_d   = syn_q;
        err_d   = err_q;
        if (acc_c) begin
            state_d = ST_FULL;
            last_d  = gnt_idx_c;
            id_d    = gnt_idx_c;
            op_d    = sel_op_c;
            if (sel_op_c == OP_DEC) begin
                code_d = corr_code_c;
                data_d = corr_data_c;
                syn_d  = synd_c;
                err_d  = (synd_c != '0);
            end else begin
                code_d = enc_code_c;
                data_d = sel_word_c[3:0];
                syn_d  = '0;
                err_d  = 1'b0;
            end
        end else if (rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            op_q    <= 1'b0;
            code_q  <= '0;
            data_q  <= '0;
            syn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            code_q  <= code_d;
            data_q  <= data_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid    = (state_q == ST_FULL);
    assign rsp_id       = id_q;
    assign rsp_op       = op_q;
    assign rsp_code     = code_q;
    assign rsp_data     = data_q;
    assign rsp_syndrome = syn_q;
    assign rsp_err      = err_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of accepted decodes with a nonzero syndrome.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc_c && (sel_op_c == OP_DEC) && (synd_c != '0) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Directed bench for hamming_codec_arbiter with a behavioural reference model.
module tb_hamming_codec_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned ECW  = 2;
`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_op;
    logic [NREQ-1:0]   req_ptype;
    logic [7*NREQ-1:0] req_word;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic              rsp_op;
    logic [6:0]        rsp_code;
    logic [3:0]        rsp_data;
    logic [2:0]        rsp_syndrome;
    logic              rsp_err;
    logic [ECW-1:0]    err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hamming_codec_arbiter #(.NREQ(NREQ), .ERR_CNT_W(ECW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_ptype    (req_ptype),
        .req_word     (req_word),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_op       (rsp_op),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_syndrome (rsp_syndrome),
        .rsp_err      (rsp_err),
        .err_count    (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // XOR of the positions of all set bits: zero for a valid even codeword.
    function automatic logic [2:0] pos_xor(input logic [7:1] c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 1; i <= 7; i++) if (c[i]) s = s ^ 3'(i);
        return s;
    endfunction

    function automatic logic [7:1] model_enc(input logic [4:1] d, input logic pt);
        logic [7:1] c;
        logic [2:0] s;
        c = '0;
        c[3] = d[1]; c[5] = d[2]; c[6] = d[3]; c[7] = d[4];
        s = pos_xor(c) ^ {3{pt}};
        c[1] = s[0]; c[2] = s[1]; c[4] = s[2];
        return c;
    endfunction

    // Reference model state.
    logic       m_full;
    int         m_last;
    int         m_id;
    logic       m_op;
    logic [7:1] m_code;
    logic [4:1] m_data;
    logic [2:0] m_syn;
    logic       m_err;
    int         m_cnt;

    int         g;
    logic [1:0] exp_rdy;
    logic [6:0] w;
    logic       pt;

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            m_full = 1'b0; m_last = NREQ - 1; m_id = 0; m_op = 1'b0;
            m_code = '0; m_data = '0; m_syn = '0; m_err = 1'b0; m_cnt = 0;
        end
        check("m_rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("m_rsp_id",   32'(rsp_id),       32'(m_id));
            check("m_rsp_op",   32'(rsp_op),       32'(m_op));
            check("m_rsp_code", 32'(rsp_code),     32'(m_code));
            check("m_rsp_data", 32'(rsp_data),     32'(m_data));
            check("m_rsp_syn",  32'(rsp_syndrome), 32'(m_syn));
            check("m_rsp_err",  32'(rsp_err),      32'(m_err));
        end
        check("m_err_count", 32'(err_count), CNT_EN ? 32'(m_cnt) : 32'd0);
        g = -1;
        exp_rdy = '0;
        if (!rst && (req_valid != '0) && (!m_full || rsp_ready)) begin
            for (int d = 1; d <= NREQ; d++) begin
                if (g < 0 && req_valid[(m_last + d) % NREQ]) g = (m_last + d) % NREQ;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("m_req_ready", 32'(req_ready), 32'(exp_rdy));
        if (!rst) begin
            if (g >= 0) begin
                w  = req_word[7*g +: 7];
                pt = req_ptype[g];
                m_full = 1'b1; m_last = g; m_id = g; m_op = req_op[g];
                if (req_op[g]) begin
                    m_syn  = pos_xor(w) ^ {3{pt}};
                    m_code = w;
                    if (m_syn != 0) m_code[m_syn] = ~m_code[m_syn];
                    m_data = {m_code[7], m_code[6], m_code[5], m_code[3]};
                    m_err  = (m_syn != 0);
                    if (m_err && m_cnt < (1 << ECW) - 1) m_cnt++;
                end else begin
                    m_code = model_enc(w[3:0], pt);
                    m_data = w[3:0];
                    m_syn  = '0;
                    m_err  = 1'b0;
                end
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic op, input logic p, input logic [6:0] wd);
        req_valid[i]       = v;
        req_op[i]          = op;
        req_ptype[i]       = p;
        req_word[7*i +: 7] = wd;
    endtask

    task automatic drain();
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [6:0] tbl_word [6];
    logic       tbl_pt   [6];
    logic       tbl_op   [6];

    initial begin
        req_valid = '0; req_op = '0; req_ptype = '0; req_word = '0; rsp_ready = 1'b0;
        tbl_word = '{7'b0000000, 7'b1111111, 7'b0101100, 7'b1010101, 7'b0011001, 7'b1100110};
        tbl_pt   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl_op   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) tick();
        @(negedge clk);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_code",  32'(rsp_code),  32'd0);
        check("reset_cnt",   32'(err_count), 32'd0);
        tick();
        rst = 1'b0;

        // Encode 0101 even from requester 0.
        set_req(0, 1'b1, 1'b0, 1'b0, 7'b0000101);
        @(negedge clk);
        check("enc_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("enc_valid", 32'(rsp_valid), 32'd1);
        check("enc_code",  32'(rsp_code),  32'b0101101);
        check("enc_data",  32'(rsp_data),  32'b0101);
        check("enc_err",   32'(rsp_err),   32'd0);
        check("enc_id",    32'(rsp_id),    32'd0);
        drain();

        // Decode with bit 5 flipped from requester 1.
        set_req(1, 1'b1, 1'b1, 1'b0, 7'b0111101);
        @(negedge clk);
        check("dec_ready", 32'(req_ready), 32'b10);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("dec_syn",  32'(rsp_syndrome), 32'b101);
        check("dec_data", 32'(rsp_data),     32'b0101);
        check("dec_code", 32'(rsp_code),     32'b0101101);
        check("dec_err",  32'(rsp_err),      32'd1);
        check("dec_id",   32'(rsp_id),       32'd1);
        check("dec_cnt",  32'(err_count),    CNT_EN ? 32'd1 : 32'd0);
        drain();

        // Fairness: both requesters valid, consumer always ready.
        set_req(0, 1'b1, 1'b0, 1'b0, 7'h03);
        set_req(1, 1'b1, 1'b0, 1'b1, 7'h09);
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) req_valid = '0;
            @(negedge clk);
            check("fair_id",    32'(rsp_id),    32'(k % 2));
            check("fair_valid", 32'(rsp_valid), 32'd1);
        end
        tick();
        rsp_ready = 1'b0;

        // Backpressure: hold FULL with both requesters pending.
        set_req(0, 1'b1, 1'b0, 1'b0, 7'h06);
        tick();
        set_req(1, 1'b1, 1'b1, 1'b1, 7'h55);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_code",  32'(rsp_code),  32'b0110011);
            check("bp_id",    32'(rsp_id),    32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'b10);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_id",    32'(rsp_id),    32'd1);

        // Reset while FULL.
        req_valid = 2'b11;
        tick();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_first_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rst_first_id", 32'(rsp_id), 32'd0);
        drain();

        // Saturation of the error counter.
        set_req(0, 1'b1, 1'b1, 1'b0, 7'b0111101);
        rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) req_valid = '0;
            @(negedge clk);
            check("sat_cnt", 32'(err_count), CNT_EN ? 32'((k < 3) ? k : 3) : 32'd0);
        end

        // Mixed directed vectors, alternating requesters, odd and even parity.
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid = '0;
            set_req(k % 2, 1'b1, tbl_op[k], tbl_pt[k], tbl_word[k]);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
